// File: rtl/nonce_queue.sv
// ============================================================================
// Module   : nonce_queue
// Purpose  : Collects golden-nonce reports from LOCAL_MINERS hashing cores and
//            hands them to the host readout one at a time, in order, through a
//            valid/ack handshake. Each core owns a one-deep holding register;
//            a round-robin arbiter moves held nonces into a FIFO.
// Build    : define NONCE_QUEUE_DEDUP_EN to discard a granted nonce equal to
//            the most recently pushed one (suppresses repeat reports).
// Ports    : hash_clk            - clock, rising edge
//            reset_n             - asynchronous active-low reset
//            golden_nonce_i      - per-core nonces, core k at [k*32 +: 32]
//            golden_nonce_match  - per-core single-cycle match strobes
//            golden_nonce_out    - head-of-queue nonce (0 while empty)
//            nonce_valid         - queue non-empty
//            nonce_ack           - pop head (ignored while empty)
//            count               - FIFO occupancy 0..DEPTH
//            overflow            - sticky: a held nonce was overwritten
//            clear_overflow      - clears overflow (a same-cycle drop wins)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nonce_queue #(
  parameter int LOCAL_MINERS = 1,
  parameter int DEPTH        = 8
) (
  input  logic                        hash_clk,
  input  logic                        reset_n,
  input  logic [LOCAL_MINERS*32-1:0]  golden_nonce_i,
  input  logic [LOCAL_MINERS-1:0]     golden_nonce_match,
  output logic [31:0]                 golden_nonce_out,
  output logic                        nonce_valid,
  input  logic                        nonce_ack,
  output logic [$clog2(DEPTH):0]      count,
  output logic                        overflow,
  input  logic                        clear_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = (LOCAL_MINERS > 1) ? $clog2(LOCAL_MINERS) : 1;
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [LOCAL_MINERS-1:0] pending_q, pending_d;
  logic [31:0]             hold_q [LOCAL_MINERS];
  logic [31:0]             hold_d [LOCAL_MINERS];
  logic [RW-1:0]           rr_q, rr_d;
  logic [AW-1:0]           wr_q, wr_d;
  logic [AW-1:0]           rd_q, rd_d;
  logic [CW-1:0]           count_q, count_d;
  logic                    overflow_q, overflow_d;
  logic [31:0]             mem_q [DEPTH];

  // --------------------------------------------------------------------------
  // Combinational signals
  // --------------------------------------------------------------------------
  logic                    w_pop;
  logic                    w_can_push;
  logic                    w_grant;
  logic                    w_push;
  logic                    w_dup;
  logic                    w_drop;
  logic [LOCAL_MINERS-1:0] w_req_hi;
  logic                    w_found_hi;
  int                      w_sel_hi;
  int                      w_sel_lo;
  int                      w_sel;
  logic [LOCAL_MINERS-1:0] w_gnt_oh;
  logic [31:0]             w_gnt_nonce;

  assign w_pop      = nonce_ack && (count_q != '0);
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign w_can_push = (count_q < C_DEPTH) || w_pop;
  assign w_grant    = (|pending_q) && w_can_push;

  // --------------------------------------------------------------------------
  // Round-robin arbiter: cores at or above rr take priority (lowest index
  // first); if none of those is pending, the lowest pending core wins. That
  // is exactly a cyclic search starting at rr.
  // --------------------------------------------------------------------------
  always_comb begin
    w_req_hi   = '0;
    w_found_hi = 1'b0;
    w_sel_hi   = 0;
    w_sel_lo   = 0;
    for (int k = 0; k < LOCAL_MINERS; k++) begin
      w_req_hi[k] = pending_q[k] && (k >= int'(rr_q));
    end
    // Descending scan so the lowest matching index is the one left standing.
    for (int k = LOCAL_MINERS - 1; k >= 0; k--) begin
      if (w_req_hi[k]) begin
        w_found_hi = 1'b1;
        w_sel_hi   = k;
      end
      if (pending_q[k]) begin
        w_sel_lo = k;
      end
    end
    w_sel = w_found_hi ? w_sel_hi : w_sel_lo;
  end

  always_comb begin
    w_gnt_oh    = '0;
    w_gnt_nonce = '0;
    rr_d        = rr_q;
    for (int k = 0; k < LOCAL_MINERS; k++) begin
      w_gnt_oh[k] = w_grant && (k == w_sel);
      w_gnt_nonce = w_gnt_nonce | (hold_q[k] & {32{w_gnt_oh[k]}});
      if (w_gnt_oh[k]) begin
        // With a single core this always yields 0, so rr never moves.
        rr_d = (k == LOCAL_MINERS - 1) ? '0 : RW'(k + 1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Optional duplicate suppression against the last value actually pushed.
  // --------------------------------------------------------------------------
`ifdef NONCE_QUEUE_DEDUP_EN
  logic [31:0] last_q, last_d;

  assign w_dup  = w_grant && (w_gnt_nonce == last_q);
  assign last_d = w_push ? w_gnt_nonce : last_q;

  always_ff @(posedge hash_clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q <= 32'hFFFF_FFFF;
    end else begin
      last_q <= last_d;
    end
  end
`else
  assign w_dup = 1'b0;
`endif

  assign w_push = w_grant && !w_dup;

  // --------------------------------------------------------------------------
  // Capture stage. A grant and a new match on the same core in one cycle is a
  // clean hand-over (old value pushed, new one held); only a match on a core
  // whose held value is not leaving counts as a drop.
  // --------------------------------------------------------------------------
  always_comb begin
    pending_d = pending_q;
    w_drop    = 1'b0;
    for (int k = 0; k < LOCAL_MINERS; k++) begin
      hold_d[k] = hold_q[k];
      if (w_gnt_oh[k]) begin
        pending_d[k] = 1'b0;
      end
      if (golden_nonce_match[k]) begin
        hold_d[k]    = golden_nonce_i[k*32 +: 32];
        pending_d[k] = 1'b1;
        if (pending_q[k] && !w_gnt_oh[k]) begin
          w_drop = 1'b1;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // FIFO bookkeeping
  // --------------------------------------------------------------------------
  always_comb begin
    wr_d    = w_push ? wr_q + AW'(1) : wr_q;
    rd_d    = w_pop  ? rd_q + AW'(1) : rd_q;
    count_d = count_q;
    if (w_push && !w_pop) begin
      count_d = count_q + CW'(1);
    end else if (w_pop && !w_push) begin
      count_d = count_q - CW'(1);
    end
    // A drop in the same cycle as a clear leaves the flag set.
    if (w_drop) begin
      overflow_d = 1'b1;
    end else if (clear_overflow) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  always_ff @(posedge hash_clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q  <= '0;
      rr_q       <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      for (int k = 0; k < LOCAL_MINERS; k++) begin
        hold_q[k] <= '0;
      end
    end else begin
      pending_q  <= pending_d;
      rr_q       <= rr_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      for (int k = 0; k < LOCAL_MINERS; k++) begin
        hold_q[k] <= hold_d[k];
      end
    end
  end

  // Storage array carries no reset; stale words are never visible because the
  // output is forced to zero while the queue is empty.
  always_ff @(posedge hash_clk) begin
    if (w_push) begin
      mem_q[wr_q] <= w_gnt_nonce;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs (first-word-fall-through)
  // --------------------------------------------------------------------------
  assign nonce_valid      = (count_q != '0);
  assign golden_nonce_out = nonce_valid ? mem_q[rd_q] : 32'd0;
  assign count            = count_q;
  assign overflow         = overflow_q;

endmodule

`default_nettype wire
